// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream
// Streaming 2x2 / stride-2 signed max-pool. Pixels arrive in raster order.
// Even rows reduce each horizontal pair into a half-width line buffer. Odd
// rows combine their own pair with the buffered pair to emit one value per
// window.
module maxpool_2x2_stream #(
    parameter int DATA_W = 64,
    parameter int IMG_W  = 416,
    parameter int IMG_H  = 416
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done
);

    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_D  = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    // Frame geometry must tile exactly into 2x2 windows.
    if ((IMG_W < 2) || (IMG_W % 2 != 0) || (IMG_H < 2) || (IMG_H % 2 != 0)) begin : g_bad_geom
        $error("maxpool_2x2_stream: IMG_W and IMG_H must be even and >= 2");
    end

    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_linebuf [LB_D];
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_frame_done;

    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_win_done;
    logic [LB_AW-1:0]  w_lb_idx;
    logic [DATA_W-1:0] w_pair_max;
    logic [DATA_W-1:0] w_win_max;

    // Input only stalls while a produced value is still waiting downstream.
    assign in_ready   = !(r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
    assign w_win_done = w_accept && r_row[0] && r_col[0];
    assign w_lb_idx   = LB_AW'(r_col >> 1);
    assign w_pair_max = smax(r_hold, in_data);
    assign w_win_max  = smax(r_linebuf[w_lb_idx], w_pair_max);

    // Raster position counters and the even-column hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_hold <= '0;
        end else if (w_accept) begin
            if (!r_col[0]) begin
                r_hold <= in_data;
            end
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Even rows park each horizontal pair maximum for the row below.
    always_ff @(posedge clk) begin
        if (w_accept && !r_row[0] && r_col[0]) begin
            r_linebuf[w_lb_idx] <= w_pair_max;
        end
    end

    // Output register: load on window completion, drop on acceptance.
    // Data is held after acceptance; only valid/last clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_out_valid && out_ready && r_out_last;
            if (w_win_done) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_win_max;
                r_out_last  <= w_row_last && w_col_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;

endmodule
